// File: rtl/cb_pkg.sv
// Shared types and width/select-encoding helpers for the double-buffered connection box.
package cb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERROR = 2'd3
    } cb_state_e;

    // Select field width: tracks plus const-0, const-1 and at least one "disconnected" code.
    function automatic int sel_bits_f(input int width);
        return $clog2(width + 3);
    endfunction

    // Number of frame bits, excluding the trailing parity bit.
    function automatic int frame_bits_f(input int width, input int num_le,
                                        input int le_inputs, input int le_outputs);
        return num_le * (le_inputs + le_outputs) * sel_bits_f(width);
    endfunction

    function automatic logic sel_is_track_f(input int sel, input int width);
        return (sel < width);
    endfunction

    function automatic logic sel_is_const_f(input int sel, input int width);
        return (sel == width) || (sel == width + 1);
    endfunction

    // Constant value carried by a const select (only meaningful when sel_is_const_f).
    function automatic logic sel_const_val_f(input int sel, input int width);
        return (sel == width + 1);
    endfunction

endpackage

// File: rtl/cb_dbuf_if.sv
// Configuration-chain and status signals of the connection box.
interface cb_dbuf_if;
    logic en;
    logic config_en;
    logic config_data_in;
    logic config_data_out;
    logic cfg_valid;
    logic cfg_busy;
    logic cfg_err;
    logic cfg_conflict;

    modport master (
        output en, config_en, config_data_in,
        input  config_data_out, cfg_valid, cfg_busy, cfg_err, cfg_conflict
    );

    modport slave (
        input  en, config_en, config_data_in,
        output config_data_out, cfg_valid, cfg_busy, cfg_err, cfg_conflict
    );
endinterface

// File: rtl/cb_cfg_loader.sv
// Serial configuration loader: shadow shift chain, bit counter, parity check and FSM.
// The first bit shifted in is the parity bit; it ends up in the chain MSB.
module cb_cfg_loader #(
    parameter int FRAME_BITS = 40
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_i,
    input  logic                  config_en_i,
    input  logic                  config_data_i,
    output logic                  config_data_o,
    output logic [FRAME_BITS-1:0] frame_o,
    output logic                  commit_o,
    output logic                  cfg_valid_o,
    output logic                  cfg_busy_o,
    output logic                  cfg_err_o
);
    import cb_pkg::*;

    localparam int CHAIN_BITS = FRAME_BITS + 1;
    localparam int CNT_W      = $clog2(CHAIN_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CHAIN_BITS-1:0] shadow_q;
    logic [CNT_W-1:0]      cnt_q;
    cb_state_e             state_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  parity_ok_s;

    // Even parity over the complete chain (frame plus parity bit).
    function automatic logic even_parity_ok_f(input logic [CHAIN_BITS-1:0] v);
        return ~(^v);
    endfunction

    assign parity_ok_s   = even_parity_ok_f(shadow_q);
    assign config_data_o = shadow_q[CHAIN_BITS-1];
    assign frame_o       = shadow_q[FRAME_BITS-1:0];
    assign commit_o      = en_i && (state_q == ST_CHECK) && parity_ok_s;
    assign cfg_valid_o   = valid_q;
    assign cfg_busy_o    = busy_q;
    assign cfg_err_o     = err_q;

    // Shadow chain shifting and frame FSM; everything freezes while en_i is low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_q <= '1;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (en_i) begin
            if (config_en_i) begin
                shadow_q <= {shadow_q[CHAIN_BITS-2:0], config_data_i};
            end
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (config_en_i) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= CNT_ONE;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (config_en_i && (cnt_q == CNT_FULL)) begin
                        // Overlength frame.
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (config_en_i) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else if (cnt_q == CNT_FULL) begin
                        state_q <= ST_CHECK;
                    end else begin
                        // Frame dropped early.
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    busy_q <= 1'b0;
                    if (parity_ok_s) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cb_dbuf.sv
// Double-buffered connection box: active routing register, LE input muxes and
// tristate track drivers fed by the LE outputs. Reconfiguration only touches the
// loader's shadow chain until a frame passes its parity check.
module cb_dbuf #(
    parameter int WIDTH      = 32,
    parameter int NUM_LE     = 2,
    parameter int LE_INPUTS  = 4,
    parameter int LE_OUTPUTS = 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    cb_dbuf_if.slave                      cfg,
    input  logic [NUM_LE*LE_OUTPUTS-1:0]  le_out,
    output logic [NUM_LE*LE_INPUTS-1:0]   le_in,
    inout  wire  [WIDTH-1:0]              sb_bus
);
    import cb_pkg::*;

    localparam int SEL_BITS   = sel_bits_f(WIDTH);
    localparam int MUX_PER_LE = LE_INPUTS + LE_OUTPUTS;
    localparam int NUM_OUT    = NUM_LE * LE_OUTPUTS;
    localparam int NUM_IN     = NUM_LE * LE_INPUTS;
    localparam int FRAME_BITS = frame_bits_f(WIDTH, NUM_LE, LE_INPUTS, LE_OUTPUTS);
    localparam int TRK_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [FRAME_BITS-1:0] frame_s;
    logic                  commit_s;
    logic [FRAME_BITS-1:0] active_q;
    logic [FRAME_BITS-1:0] active_d;
    logic                  conflict_s;
    logic                  conflict_q;
    logic                  conflict_d;
    logic [WIDTH-1:0]      drv_en_s;
    logic [WIDTH-1:0]      drv_val_s;
    logic [NUM_IN-1:0]     le_in_s;

    // Global mux index of output mux n (outputs follow the inputs of each LE).
    function automatic int out_mux_f(input int n);
        return (n / LE_OUTPUTS) * MUX_PER_LE + LE_INPUTS + (n % LE_OUTPUTS);
    endfunction

    cb_cfg_loader #(
        .FRAME_BITS (FRAME_BITS)
    ) u_loader (
        .clk           (clk),
        .nrst          (nrst),
        .en_i          (cfg.en),
        .config_en_i   (cfg.config_en),
        .config_data_i (cfg.config_data_in),
        .config_data_o (cfg.config_data_out),
        .frame_o       (frame_s),
        .commit_o      (commit_s),
        .cfg_valid_o   (cfg.cfg_valid),
        .cfg_busy_o    (cfg.cfg_busy),
        .cfg_err_o     (cfg.cfg_err)
    );

    assign cfg.cfg_conflict = conflict_q;

    // Flag frames in which two output muxes claim the same track.
    always_comb begin
        logic [SEL_BITS-1:0] sel_a;
        logic [SEL_BITS-1:0] sel_b;
        conflict_s = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        for (int a = 0; a < NUM_OUT; a++) begin
            for (int b = a + 1; b < NUM_OUT; b++) begin
                sel_a = frame_s[out_mux_f(a)*SEL_BITS +: SEL_BITS];
                sel_b = frame_s[out_mux_f(b)*SEL_BITS +: SEL_BITS];
                conflict_s = conflict_s |
                             (sel_is_track_f(int'(sel_a), WIDTH) && (sel_a == sel_b));
            end
        end
    end

    // Next active configuration: replaced only by a frame that passed its check.
    always_comb begin
        active_d   = commit_s ? frame_s    : active_q;
        conflict_d = commit_s ? conflict_s : conflict_q;
    end

    // Active routing register and committed conflict flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            active_q   <= '1;
            conflict_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            conflict_q <= conflict_d;
        end
    end

    // Track drivers: the lowest-index output mux selecting a track owns it.
    always_comb begin
        logic [SEL_BITS-1:0] sel_v;
        logic                hit_v;
        drv_en_s  = '0;
        drv_val_s = '0;
        sel_v     = '0;
        hit_v     = 1'b0;
        for (int n = 0; n < NUM_OUT; n++) begin
            sel_v = active_q[out_mux_f(n)*SEL_BITS +: SEL_BITS];
            for (int j = 0; j < WIDTH; j++) begin
                hit_v        = (int'(sel_v) == j) && !drv_en_s[j];
                drv_val_s[j] = hit_v ? le_out[n] : drv_val_s[j];
                drv_en_s[j]  = drv_en_s[j] | hit_v;
            end
        end
        drv_en_s = drv_en_s & {WIDTH{nrst}};
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_trk
        assign sb_bus[j] = drv_en_s[j] ? drv_val_s[j] : 1'bz;
    end

    // LE input muxes: track value, constant, or 0 when disconnected.
    always_comb begin
        int sel_i;
        le_in_s = '0;
        sel_i   = 0;
        for (int k = 0; k < NUM_LE; k++) begin
            for (int i = 0; i < LE_INPUTS; i++) begin
                sel_i = int'(active_q[(k*MUX_PER_LE + i)*SEL_BITS +: SEL_BITS]);
                if (sel_is_track_f(sel_i, WIDTH)) begin
                    le_in_s[k*LE_INPUTS + i] = sb_bus[sel_i[TRK_W-1:0]];
                end else if (sel_is_const_f(sel_i, WIDTH)) begin
                    le_in_s[k*LE_INPUTS + i] = sel_const_val_f(sel_i, WIDTH);
                end else begin
                    le_in_s[k*LE_INPUTS + i] = 1'b0;
                end
            end
        end
    end

    assign le_in = le_in_s & {NUM_IN{nrst}};

endmodule

// File: tb/tb_cb_dbuf.sv
// Randomized bench for cb_dbuf (WIDTH=8, 2 LEs x 4 inputs x 1 output).
module tb_cb_dbuf;

    localparam int WIDTH      = 8;
    localparam int NUM_LE     = 2;
    localparam int LE_INPUTS  = 4;
    localparam int LE_OUTPUTS = 1;
    localparam int MUXES      = 10;
    localparam int FRAME_BITS = 40;
    localparam int CHAIN      = 41;
    localparam int DISC       = 15;

    typedef int sel_arr_t [MUXES];

    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] le_out;
    logic [7:0] le_in;
    wire  [7:0] sb_bus;
    logic [7:0] tb_drv_en;
    logic [7:0] tb_drv_val;

    cb_dbuf_if cfg ();

    always #5 clk = ~clk;

    for (genvar j = 0; j < WIDTH; j++) begin : g_drv
        assign sb_bus[j] = tb_drv_en[j] ? tb_drv_val[j] : 1'bz;
    end

    cb_dbuf #(
        .WIDTH      (WIDTH),
        .NUM_LE     (NUM_LE),
        .LE_INPUTS  (LE_INPUTS),
        .LE_OUTPUTS (LE_OUTPUTS)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .cfg    (cfg),
        .le_out (le_out),
        .le_in  (le_in),
        .sb_bus (sb_bus)
    );

    int       checks = 0;
    int       errors = 0;
    sel_arr_t act_sel;
    bit       exp_valid;
    bit       exp_err;
    bit       exp_conflict;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Chain as shifted: bit CHAIN-1 first (parity), then frame bit 39 down to 0.
    function automatic logic [CHAIN-1:0] make_chain(input sel_arr_t s, input bit flip);
        logic [FRAME_BITS-1:0] f;
        int                    v;
        f = '0;
        for (int m = 0; m < MUXES; m++) begin
            v = s[m];
            f[m*4 +: 4] = v[3:0];
        end
        return {(^f) ^ flip, f};
    endfunction

    function automatic bit conflict_of(input sel_arr_t s);
        return (s[4] < WIDTH) && (s[4] == s[9]);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < MUXES; m++) act_sel[m] = DISC;
        exp_valid    = 1'b0;
        exp_err      = 1'b0;
        exp_conflict = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_valid"},    cfg.cfg_valid,    exp_valid);
        check_val({tag, "_err"},      cfg.cfg_err,      exp_err);
        check_val({tag, "_conflict"}, cfg.cfg_conflict, exp_conflict);
        check_val({tag, "_busy"},     cfg.cfg_busy,     1'b0);
    endtask

    // Random LE outputs and bench track values; compare tracks and LE inputs to the model.
    task automatic check_routing(input string tag, input int iters);
        logic [7:0] tval, exp_drv, exp_trk, exp_lein;
        int         s;
        for (int it = 0; it < iters; it++) begin
            le_out = 2'($urandom);
            tval   = 8'($urandom);
            for (int j = 0; j < WIDTH; j++) begin
                exp_drv[j] = 1'b0;
                exp_trk[j] = tval[j];
                for (int n = NUM_LE - 1; n >= 0; n--) begin
                    if (nrst && act_sel[n*5 + 4] == j) begin
                        exp_drv[j] = 1'b1;
                        exp_trk[j] = le_out[n];
                    end
                end
            end
            for (int k = 0; k < NUM_LE; k++) begin
                for (int i = 0; i < LE_INPUTS; i++) begin
                    s = act_sel[k*5 + i];
                    if (!nrst)           exp_lein[k*4 + i] = 1'b0;
                    else if (s < WIDTH)  exp_lein[k*4 + i] = exp_trk[s];
                    else if (s == WIDTH + 1) exp_lein[k*4 + i] = 1'b1;
                    else                 exp_lein[k*4 + i] = 1'b0;
                end
            end
            tb_drv_en  = ~exp_drv;
            tb_drv_val = tval;
            #1;
            check_val({tag, "_bus"},  sb_bus, exp_trk);
            check_val({tag, "_lein"}, le_in,  exp_lein);
        end
    endtask

    task automatic send_chain(input logic [CHAIN-1:0] ch, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            cfg.config_en      = 1'b1;
            cfg.config_data_in = (i < CHAIN) ? ch[CHAIN-1-i] : 1'($urandom);
            @(negedge clk);
        end
        cfg.config_en      = 1'b0;
        cfg.config_data_in = 1'b0;
    endtask

    // Ship a frame, step through the check, then update and compare against the model.
    task automatic load(input string tag, input sel_arr_t s, input bit flip, input int nbits);
        logic [CHAIN-1:0] ch;
        bit               good;
        ch   = make_chain(s, flip);
        good = (nbits == CHAIN) && !flip;
        send_chain(ch, nbits);
        check_val({tag, "_busy_end"}, cfg.cfg_busy, (nbits <= CHAIN));
        @(negedge clk);
        if (nbits == CHAIN) begin
            check_val({tag, "_busy_chk"},  cfg.cfg_busy,  1'b1);
            check_val({tag, "_valid_chk"}, cfg.cfg_valid, exp_valid);
        end else begin
            check_val({tag, "_err_early"}, cfg.cfg_err, 1'b1);
        end
        @(negedge clk);
        if (good) begin
            act_sel      = s;
            exp_valid    = 1'b1;
            exp_err      = 1'b0;
            exp_conflict = conflict_of(s);
            check_val({tag, "_dout"}, cfg.config_data_out, ch[CHAIN-1]);
        end else begin
            exp_err = 1'b1;
        end
        check_status(tag);
        check_routing(tag, 4);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        cfg.en = 1'b1;
        cfg.config_en = 1'b0;
        cfg.config_data_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        sel_arr_t         s2, s;
        logic [CHAIN-1:0] ch;
        int               r;

        le_out     = 2'b00;
        tb_drv_en  = 8'h00;
        tb_drv_val = 8'h00;
        do_reset();

        // Reset state.
        check_status("rst");
        check_val("rst_dout", cfg.config_data_out, 1'b1);
        check_routing("rst", 4);

        // Good frame: input mux 0 -> track 3, LE0 output -> track 5.
        s2 = '{default: DISC};
        s2[0] = 3;
        s2[4] = 5;
        load("good", s2, 1'b0, CHAIN);
        le_out = 2'b01;
        tb_drv_en = 8'hDF;
        tb_drv_val = 8'h08;
        #1;
        check_val("good_trk5", sb_bus[5], 1'b1);
        check_val("good_lein0", le_in[0], 1'b1);

        // Parity error from reset: nothing committed.
        do_reset();
        load("parity", s2, 1'b1, CHAIN);

        // Reload with early drop while the good frame routes.
        do_reset();
        load("base", s2, 1'b0, CHAIN);
        for (int m = 0; m < MUXES; m++) s[m] = int'($urandom_range(0, 15));
        ch = make_chain(s, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cfg.config_en      = 1'b1;
            cfg.config_data_in = ch[CHAIN-1-i];
            le_out             = 2'($urandom);
            #1;
            check_val("reload_trk5", sb_bus[5], le_out[0]);
            @(negedge clk);
        end
        cfg.config_en = 1'b0;
        @(negedge clk);
        exp_err = 1'b1;
        check_status("drop");
        check_routing("drop", 4);

        // Output conflict: both outputs on track 2, LE0 wins.
        s = '{default: DISC};
        s[4] = 2;
        s[9] = 2;
        s[1] = 2;
        load("conflict", s, 1'b0, CHAIN);

        // Random frames with random faults (parity, short, overlength).
        for (int f = 0; f < 10; f++) begin
            for (int m = 0; m < MUXES; m++) s[m] = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) s[9] = s[4];
            r = int'($urandom_range(0, 5));
            case (r)
                0:       load("rnd_par",  s, 1'b1, CHAIN);
                1:       load("rnd_short", s, 1'b0, int'($urandom_range(1, FRAME_BITS)));
                2:       load("rnd_long", s, 1'b0, CHAIN + 1);
                default: load("rnd_good", s, 1'b0, CHAIN);
            endcase
        end

        // Freeze mid-frame: counter and shadow hold, frame still completes exactly.
        for (int m = 0; m < MUXES; m++) s[m] = int'($urandom_range(0, 15));
        ch = make_chain(s, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cfg.config_en      = 1'b1;
            cfg.config_data_in = ch[CHAIN-1-i];
            @(negedge clk);
        end
        cfg.en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cfg.config_data_in = 1'($urandom);
            @(negedge clk);
            check_val("freeze_busy", cfg.cfg_busy, 1'b1);
        end
        cfg.en = 1'b1;
        for (int i = 10; i < CHAIN; i++) begin
            cfg.config_data_in = ch[CHAIN-1-i];
            @(negedge clk);
        end
        cfg.config_en = 1'b0;
        repeat (2) @(negedge clk);
        act_sel      = s;
        exp_valid    = 1'b1;
        exp_err      = 1'b0;
        exp_conflict = conflict_of(s);
        check_status("freeze");
        check_routing("freeze", 4);

        // Reset pulse mid-frame: outputs return to reset values at once.
        send_chain(ch, 15);
        cfg.config_en = 1'b1;
        nrst = 1'b0;
        model_reset();
        #1;
        check_status("arst");
        check_val("arst_dout", cfg.config_data_out, 1'b1);
        check_routing("arst", 3);
        cfg.config_en = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_status("post_rst");
        check_routing("post_rst", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_dbuf.md
CB_DBUF -- requirements
Module: cb_dbuf

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of switchbox tracks on sb_bus.
REQ-002 SHALL have parameter NUM_LE, default 2: number of logic elements served (channels).
REQ-003 SHALL have parameter LE_INPUTS, default 4: inputs per LE.
REQ-004 SHALL have parameter LE_OUTPUTS, default 1: outputs per LE.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, ports clk and nrst.
REQ-006 Ports: clk  in  1  clock; nrst  in  1  async active-low reset.
REQ-007 Ports: en  in  1  global enable, freezes the config loader when low; config_en  in  1  configuration frame strobe.
REQ-008 Ports: config_data_in  in  1  serial config bit; config_data_out  out  1  chain output to the next block.
REQ-009 Ports: le_out  in  NUM_LE*LE_OUTPUTS  LE outputs, LE k output o at bit k*LE_OUTPUTS+o; le_in  out  NUM_LE*LE_INPUTS  LE inputs, same packing.
REQ-010 Ports: sb_bus  inout  WIDTH  switchbox tracks.
REQ-011 Ports: cfg_valid, cfg_busy, cfg_err, cfg_conflict  out  1 each  loader status.

Function
REQ-012 Width rules: SEL_BITS = clog2(WIDTH+3); MUXES = NUM_LE*(LE_INPUTS+LE_OUTPUTS); FRAME_BITS = MUXES*SEL_BITS; chain length = FRAME_BITS+1, the extra bit being even parity.
REQ-013 Select encoding: 0..WIDTH-1 = track; WIDTH = const 0; WIDTH+1 = const 1; any other value = disconnected.
REQ-014 Mux m occupies shadow bits [(m+1)*SEL_BITS-1 -: SEL_BITS]; m = k*(LE_INPUTS+LE_OUTPUTS)+i, with inputs first and outputs after.
REQ-015 Double buffering: routing always uses the active register; shifting only touches the shadow register, so routing is undisturbed while configuring.
REQ-016 The shadow register shifts left by one bit, LSB <= config_data_in, on each edge with en && config_en; config_data_out = shadow MSB.
REQ-017 FSM states: IDLE, SHIFT, CHECK, ERROR.
REQ-018 IDLE/ERROR -> SHIFT on en && config_en, with the bit counter = 1 after that edge; cfg_err clears on the same edge.
REQ-019 SHIFT: the counter increments per shifted bit; when the counter reaches FRAME_BITS+1 and config_en is low -> CHECK.
REQ-020 SHIFT, config_en low with counter < FRAME_BITS+1 -> ERROR; cfg_err=1; active unchanged.
REQ-021 SHIFT, config_en high with counter = FRAME_BITS+1 (overlength frame) -> ERROR on that edge.
REQ-022 CHECK lasts one cycle; at its closing edge the transition is:
  - XOR of all shadow bits = 0: active <= shadow frame bits, cfg_valid <= 1, go IDLE;
  - otherwise: cfg_err <= 1, go ERROR, active unchanged.
REQ-023 cfg_conflict is registered at commit: 1 iff two output muxes of the committed frame select the same track.
REQ-024 en low holds FSM, counter and shadow; routing continues.
REQ-025 cfg_busy = 1 in SHIFT and CHECK.
REQ-026 le_in bit = selected track value, 0, or 1 per REQ-013; 0 when disconnected or when nrst is low.
REQ-027 Track j is driven by le_out of the lowest-index output mux selecting j; otherwise Z; all tracks Z while nrst is low.

Reset
REQ-028 nrst low asynchronously sets:
  - active and shadow registers to all ones (all disconnected);
  - FSM to IDLE, counter to 0;
  - cfg_valid, cfg_busy, cfg_err and cfg_conflict to 0.
REQ-029 Reset mid-frame discards the partial frame; no partial commit ever reaches active.

Structure
REQ-030 Package cb_pkg SHALL hold the FSM state enum, the select-encoding helper functions and the SEL_BITS/FRAME_BITS computation functions.
REQ-031 Sub-module cb_cfg_loader SHALL contain the shift register, counter, parity and FSM; cb_dbuf SHALL contain the active register and the muxes/drivers.

Verification (WIDTH=8, NUM_LE=2, LE_INPUTS=4, LE_OUTPUTS=1: SEL_BITS=4, FRAME_BITS=40, chain 41)
REQ-032 Scenario 1, reset:
  - stimulus: reset;
  - response: le_in=0x00, sb_bus=Z, cfg_valid=0, config_data_out=1.
REQ-033 Scenario 2, good frame:
  - stimulus: 41-bit frame with input mux 0 = 3, output mux of LE0 = 5, rest 15, correct parity; le_out[0]=1;
  - response: two cycles after the last bit cfg_valid=1, sb_bus[5]=1, le_in[0] follows sb_bus[3].
REQ-034 Scenario 3, parity error:
  - stimulus: the same frame with parity flipped;
  - response: cfg_err=1, active unchanged, sb_bus[5] not driven.
REQ-035 Scenario 4, routing during reload and early drop:
  - stimulus: with scenario 2 active, load a new frame and drop config_en after 20 bits;
  - response: sb_bus[5] stays driven throughout, cfg_err=1.
REQ-036 Scenario 5, conflict:
  - stimulus: both output muxes = 2;
  - response: cfg_conflict=1, sb_bus[2] = le_out[0] only.
REQ-037 Scenario 6, freeze and reset:
  - stimulus: en=0 for 5 cycles mid-frame, then nrst pulse;
  - response: counter frozen while en=0, then all outputs at reset values.
